// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle between the OTTER fetch/data requesters, the shared memory port and the arbiter.
// The arbiter takes the slave view; requesters plus memory take the master view.
interface otter_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        dm_err;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Two-requester (fetch / data) arbiter for a single memory port, with DM priority,
// bounded IF starvation and a mem_ack timeout. Every output comes straight from a flop.
module otter_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  otter_mem_arbiter_if.slave bus
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int unsigned WW = 8;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_e;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [1:0]      mem_size_q, mem_size_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
  logic            if_ack_q, if_ack_d;
  logic            if_err_q, if_err_d;
  logic            dm_ack_q, dm_ack_d;
  logic            dm_err_q, dm_err_d;
  logic            busy_q, busy_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            pulse_out;
  logic            if_must_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      busy_q      <= 1'b0;
      starve_q    <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      if_err_q    <= if_err_d;
      dm_ack_q    <= dm_ack_d;
      dm_err_q    <= dm_err_d;
      busy_q      <= busy_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
    end
  end

  // An outstanding ack/err pulse means a requester may still be holding its old
  // request; arbitration pauses that cycle so the completed request is never re-granted.
  assign pulse_out   = if_ack_q | if_err_q | dm_ack_q | dm_err_q;
  assign if_must_win = bus.if_req && (starve_q == SW'(STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    dm_ack_d    = 1'b0;
    dm_err_d    = 1'b0;
    starve_d    = starve_q;
    wait_d      = wait_q;

    case (state_q)
      IDLE: begin
        if (!pulse_out) begin
          if (bus.dm_req && !if_must_win) begin
            state_d     = GNT_DM;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.dm_we;
            mem_size_d  = bus.dm_size;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
            wait_d      = '0;
            if (!bus.if_req)                          starve_d = '0;
            else if (starve_q != SW'(STARVE_MAX))     starve_d = starve_q + SW'(1);
          end else if (bus.if_req) begin
            state_d     = GNT_IF;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_size_d  = 2'b10;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            wait_d      = '0;
            starve_d    = '0;
          end
        end
      end
      GNT_IF, GNT_DM: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == GNT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
          end
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          // Abort: report ack+err together and leave the read data untouched.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == GNT_IF) begin
            if_ack_d = 1'b1;
            if_err_d = 1'b1;
          end else begin
            dm_ack_d = 1'b1;
            dm_err_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_err    = if_err_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.busy      = busy_q;

endmodule
